// File: rtl/johnson_pkg.sv
// Shared types and sizing helpers for the Johnson counter checkers.
package johnson_pkg;
    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

    localparam int ERR_W = 8;

    // An N-bit Johnson register walks through 2N distinct states.
    function automatic int index_width(input int n);
        return (n < 1) ? 1 : $clog2(2 * n);
    endfunction
endpackage

// File: rtl/johnson_code_check.sv
// Combinational Johnson word check: legality and decoded state index.
module johnson_code_check
    import johnson_pkg::*;
#(
    parameter  int N  = 8,
    localparam int IW = index_width(N)
) (
    input  logic [N-1:0]  code,
    output logic          legal,
    output logic [IW-1:0] index
);
    int edges;
    int ones;

    always_comb begin
        edges = 0;
        ones  = 0;
        for (int i = 0; i < N - 1; i++) edges += (code[i] != code[i+1]) ? 1 : 0;
        for (int i = 0; i < N; i++)     ones  += code[i] ? 1 : 0;
    end

    // A legal word has at most one 0/1 boundary; the MSB says which half of the cycle.
    assign legal = (edges <= 1);
    assign index = code[N-1] ? IW'(2 * N - ones) : IW'(ones);
endmodule

// File: rtl/johnson_decoder.sv
// Receive-side Johnson checker: decode, sequence lock tracking, saturating error count.
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter  int N        = 8,
    parameter  int LOCK_LEN = 4,
    localparam int IW       = index_width(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     code_in,
    input  logic             code_valid,
    input  logic             dir_up,
    input  logic             err_clr,
    output logic [IW-1:0]    index,
    output logic             index_valid,
    output logic             illegal,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);
    localparam logic [IW-1:0] LAST    = IW'(2 * N - 1);
    localparam logic [3:0]    RUN_MAX = 4'(LOCK_LEN);

    lock_state_t   state;
    logic          prev_ok;
    logic [3:0]    run;
    logic          legal;
    logic [IW-1:0] dec;
    logic [IW-1:0] succ;
    logic          step_ok;
    logic          stall;
    logic          err_event;

    johnson_code_check #(.N(N)) u_check (
        .code  (code_in),
        .legal (legal),
        .index (dec)
    );

    // index doubles as the previous-sample register.
    assign succ = dir_up ? ((index == LAST) ? '0 : index + IW'(1))
                         : ((index == '0) ? LAST : index - IW'(1));
    assign step_ok   = prev_ok && (dec == succ);
    assign stall     = prev_ok && (dec == index);
    assign err_event = code_valid && (!legal || (state == LOCKED && !step_ok && !stall));
    assign locked    = (state == LOCKED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= UNLOCKED;
            prev_ok     <= 1'b0;
            run         <= '0;
            index       <= '0;
            index_valid <= 1'b0;
            illegal     <= 1'b0;
            seq_err     <= 1'b0;
            err_count   <= '0;
        end else begin
            index_valid <= 1'b0;
            illegal     <= 1'b0;
            seq_err     <= 1'b0;

            if (err_clr)
                err_count <= '0;
            else if (err_event && err_count != '1)
                err_count <= err_count + 1'b1;

            if (code_valid) begin
                if (!legal) begin
                    illegal <= 1'b1;
                    run     <= '0;
                    prev_ok <= 1'b0;
                    state   <= UNLOCKED;
                end else begin
                    index_valid <= 1'b1;
                    index       <= dec;
                    prev_ok     <= 1'b1;
                    if (state == UNLOCKED) begin
                        if (step_ok) begin
                            run <= run + 4'd1;
                            if (run + 4'd1 == RUN_MAX) state <= LOCKED;
                        end else if (!stall) begin
                            run <= '0;
                        end
                    end else if (!step_ok && !stall) begin
                        seq_err <= 1'b1;
                        run     <= '0;
                        state   <= UNLOCKED;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder with a reference model feeding a scoreboard queue.
module tb_johnson_decoder;
    import johnson_pkg::*;

    localparam int N  = 8;
    localparam int LL = 4;
    localparam int IW = index_width(N);
    localparam int S  = 2 * N;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     code_in = '0;
    logic             code_valid = 1'b0;
    logic             dir_up = 1'b1;
    logic             err_clr = 1'b0;
    logic [IW-1:0]    index;
    logic             index_valid, illegal, seq_err, locked;
    logic [ERR_W-1:0] err_count;

    johnson_decoder #(.N(N), .LOCK_LEN(LL)) dut (
        .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
        .dir_up(dir_up), .err_clr(err_clr), .index(index), .index_valid(index_valid),
        .illegal(illegal), .seq_err(seq_err), .locked(locked), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] idx;
        logic          iv, ill, se, lk;
        logic [7:0]    cnt;
    } exp_t;

    exp_t sb[$];
    int checks = 0, failures = 0, nstep = 0;
    int m_prev, m_ok, m_run, m_lock, m_cnt;

    // k-th Johnson word: k ones filling from the LSB, then zeros filling from the LSB.
    function automatic logic [N-1:0] jword(input int k);
        int w;
        if (k <= N) w = (1 << k) - 1;
        else        w = ((1 << N) - 1) ^ ((1 << (k - N)) - 1);
        return N'(w);
    endfunction

    task automatic ref_decode(input logic [N-1:0] c, output bit ok, output int idx);
        ok = 0; idx = 0;
        for (int k = 0; k < S; k++)
            if (jword(k) == c) begin ok = 1; idx = k; end
    endtask

    task automatic model_reset();
        m_prev = 0; m_ok = 0; m_run = 0; m_lock = 0; m_cnt = 0;
    endtask

    task automatic model_step(input logic [N-1:0] c, input bit v, input bit d, input bit clr);
        exp_t e;
        bit ok, err, good, st;
        int idx, nxt;
        e.iv = 0; e.ill = 0; e.se = 0; err = 0;
        if (v) begin
            ref_decode(c, ok, idx);
            if (!ok) begin
                e.ill = 1; err = 1; m_lock = 0; m_ok = 0; m_run = 0;
            end else begin
                nxt  = d ? (m_prev + 1) % S : (m_prev + S - 1) % S;
                good = (m_ok != 0) && idx == nxt;
                st   = (m_ok != 0) && idx == m_prev;
                if (m_lock != 0) begin
                    if (!(good || st)) begin e.se = 1; err = 1; m_lock = 0; m_run = 0; end
                end else if (good) begin
                    m_run++;
                    if (m_run == LL) m_lock = 1;
                end else if (!st) begin
                    m_run = 0;
                end
                m_prev = idx; m_ok = 1; e.iv = 1;
            end
        end
        if (clr) m_cnt = 0;
        else if (err && m_cnt < 255) m_cnt++;
        e.idx = IW'(m_prev); e.lk = (m_lock != 0); e.cnt = 8'(m_cnt);
        sb.push_back(e);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, nstep, obs, expv);
        end
    endtask

    task automatic compare_pop();
        exp_t e;
        checks++;
        assert (sb.size() > 0) else begin
            failures++;
            $error("FAIL scoreboard_empty step=%0d observed=0 expected=1", nstep);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("index", 32'(index), 32'(e.idx));
            check("index_valid", 32'(index_valid), 32'(e.iv));
            check("illegal", 32'(illegal), 32'(e.ill));
            check("seq_err", 32'(seq_err), 32'(e.se));
            check("locked", 32'(locked), 32'(e.lk));
            check("err_count", 32'(err_count), 32'(e.cnt));
        end
    endtask

    task automatic step(input logic [N-1:0] c, input bit v, input bit d, input bit clr);
        @(negedge clk);
        code_in = c; code_valid = v; dir_up = d; err_clr = clr;
        model_step(c, v, d, clr);
        @(posedge clk);
        #1;
        nstep++;
        compare_pop();
        code_valid = 1'b0; err_clr = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_index"}, 32'(index), 0);
        check({tag, "_iv"}, 32'(index_valid), 0);
        check({tag, "_illegal"}, 32'(illegal), 0);
        check({tag, "_seq_err"}, 32'(seq_err), 0);
        check({tag, "_locked"}, 32'(locked), 0);
        check({tag, "_err_count"}, 32'(err_count), 0);
    endtask

    logic [N-1:0] up5[5]   = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F};
    logic [N-1:0] walk[12] = '{8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFE, 8'hFC,
                               8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
    logic [N-1:0] relk[4]  = '{8'h3F, 8'h7F, 8'hFF, 8'hFE};

    initial begin
        model_reset();
        #12;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // lock on the first up run
        foreach (up5[i]) step(up5[i], 1, 1, 0);
        check("locked_after5", 32'(locked), 1);

        // climb to 14, wrap 15 -> 0, then walk down through the wrap
        foreach (walk[i]) step(walk[i], 1, 1, 0);
        step(8'h00, 1, 0, 0);
        step(8'h80, 1, 0, 0);
        step(8'hC0, 1, 0, 0);
        check("wrap_locked", 32'(locked), 1);
        check("wrap_no_err", 32'(err_count), 0);

        // illegal word while locked
        step(8'h05, 1, 0, 0);
        check("illegal_cnt", 32'(err_count), 1);
        check("illegal_hold", 32'(index), 14);
        check("illegal_unlock", 32'(locked), 0);

        // relock, back up to 3, jump to 5
        foreach (up5[i]) step(up5[i], 1, 1, 0);
        step(8'h07, 1, 0, 0);
        check("at3_locked", 32'(locked), 1);
        step(8'h1F, 1, 1, 0);
        check("seqerr_cnt", 32'(err_count), 2);
        check("seqerr_unlock", 32'(locked), 0);
        foreach (relk[i]) step(relk[i], 1, 1, 0);
        check("relock", 32'(locked), 1);
        step(8'hFE, 1, 1, 0);
        step(8'h00, 0, 1, 0);

        // saturation and clear priority
        for (int i = 0; i < 260; i++) step(8'h05, 1, 1, 0);
        check("saturate", 32'(err_count), 255);
        step(8'h05, 1, 1, 1);
        check("clear_wins", 32'(err_count), 0);

        // asynchronous reset while locked
        foreach (up5[i]) step(up5[i], 1, 1, 0);
        check("pre_rst_locked", 32'(locked), 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        sb.delete();
        step(8'h7F, 1, 1, 0);
        check("post_rst_no_seqerr", 32'(seq_err), 0);
        step(8'hFF, 1, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
